// File: rtl/sc_ifetch_if.sv
// rtl/sc_ifetch_if.sv - instruction memory req/ack fetch bus
interface sc_ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/sc_ifetch.sv
// rtl/sc_ifetch.sv - fetch stage: owns pc, fetches over req/ack, issues exec_en windows
module sc_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              resetn,
  sc_ifetch_if.master       imem,
  input  logic              exec_stall,
  input  logic [1:0]        pcsource,
  input  logic [31:0]       da,
  output logic [31:0]       inst,
  output logic [5:0]        op,
  output logic [5:0]        func,
  output logic [31:0]       pc,
  output logic [31:0]       pc4,
  output logic              exec_en,
  output logic              misalign
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  state;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic [31:0] npc;

  always_comb begin
    pc4 = pc + 32'd4;
    bpc = pc4 + {{14{inst[15]}}, inst[15:0], 2'b00};
    jpc = {pc4[31:28], inst[25:0], 2'b00};
    case (pcsource)
      2'b00:   npc = pc4;
      2'b01:   npc = bpc;
      2'b10:   npc = da;
      default: npc = jpc;
    endcase
  end

  // Outputs decode straight from state so an asynchronous reset drops req at once.
  assign imem.imem_req  = (state == S_FETCH);
  assign imem.imem_addr = pc;
  assign exec_en        = (state == S_EXEC);
  assign op             = inst[31:26];
  assign func           = inst[5:0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      inst     <= 32'h0;
      misalign <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem.imem_ack) begin
            inst  <= imem.imem_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!exec_stall) begin
            // Only a jr target can be misaligned; halt rather than fetch from it.
            if (npc[1:0] == 2'b00) begin
              pc    <= npc;
              state <= S_FETCH;
            end else begin
              misalign <= 1'b1;
              state    <= S_HALT;
            end
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: doc/sc_ifetch.md
Name: sc_ifetch

Overview:
Instruction-fetch stage that sits directly upstream of the single-cycle control unit. Owns the program counter and fetches from a variable-latency instruction memory over a req/ack handshake. Holds the fetched word in an instruction register and presents op/func to the control unit. Consumes the control unit's pcsource and the datapath's zero-independent branch/jump operands to form the next PC. Each instruction is issued for execution by a one-or-more-cycle exec_en window.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address; equals pc
imem_ack  in  1  instruction memory data valid
imem_rdata  in  32  instruction word, sampled only on accepted ack
exec_stall  in  1  datapath needs extra cycles for the current instruction
pcsource  in  2  next-PC select from control unit: 00 pc+4, 01 branch, 10 jr, 11 j/jal
da  in  32  register-file rs value (jr target)
inst  out  32  instruction register
op  out  6  inst[31:26]
func  out  6  inst[5:0]
pc  out  32  address of the instruction in inst
pc4  out  32  pc + 4 (jal link value)
exec_en  out  1  inst is valid; datapath may execute and commit this cycle
misalign  out  1  sticky: non-word-aligned next PC detected; fetch halted

Behaviour:
- States: IDLE, FETCH, EXEC, HALT. Encoding is free.
- Reset (resetn=0, asynchronous) sets the following, in the same instant, regardless of the current state:
  - state=IDLE, pc=RESET_PC, inst=32'h0 (sll $0,$0,0 = nop).
  - imem_req=0, exec_en=0, misalign=0.
- IDLE: always moves to FETCH on the next edge. No request is issued in IDLE.
- FETCH:
  - imem_req=1, with imem_addr=pc held stable for the whole state.
  - On an edge with imem_ack=1: inst<=imem_rdata and the state moves to EXEC.
  - Ack in the same cycle req rises is legal. Minimum fetch is therefore 1 cycle.
  - imem_ack while not in FETCH is ignored, and inst is unchanged.
- EXEC:
  - exec_en=1 and imem_req=0. op and func reflect inst combinationally.
  - If exec_stall=1: remain in EXEC, pc and inst hold, exec_en stays 1.
  - If exec_stall=0, on the edge: compute npc. Then:
    - if npc[1:0]==0: pc<=npc and go to FETCH;
    - otherwise: pc holds, misalign<=1, go to HALT.
- Next-PC formation (combinational, all modulo 2^32, wrap silently):
  - pc4 = pc + 4.
  - bpc = pc4 + {{14{inst[15]}}, inst[15:0], 2'b00}.
  - jpc = {pc4[31:28], inst[25:0], 2'b00}.
  - npc select: 00→pc4, 01→bpc, 10→da, 11→jpc.
  - Only jr (10) can produce a misaligned npc.
- HALT: imem_req=0 and exec_en=0. Stays in HALT until reset; misalign stays 1.
- Throughput: one instruction per (fetch latency + 1 + stall cycles); minimum one instruction per 2 cycles.
- pcsource and da are sampled only on the committing EXEC edge. Their values in other states are don't-care.
- Reset asserted mid-FETCH: req drops immediately. A late ack arriving after reset release, while in IDLE, is ignored.
- pc=32'hFFFF_FFFC with pcsource=00 gives npc=0. This is legal and not an error.

Test Plan:
- Reset then 0-wait memory (ack same cycle as req), 3 sequential instructions with pcsource=00: imem_addr = 0,4,8; exec_en high 1 cycle in every 2; inst matches each rdata.
- Memory with 3-cycle ack latency: req held 3 cycles with addr stable; rdata garbage while ack=0 is never captured.
- pc=0x100, inst=beq with imm=16'hFFFF, pcsource=01 → next imem_addr=0x100. Then pc=0x200, inst=j with target field 0x40, pcsource=11 → next addr=0x100.
- exec_stall=1 for 2 cycles in EXEC: exec_en stays high 3 cycles, pc constant, single PC update after stall drops.
- jr with da=0x1002, pcsource=10 → misalign=1, HALT, req stays 0, pc unchanged; resetn pulse → pc=RESET_PC, misalign=0, fetch resumes.
- pc=0xFFFF_FFFC with pcsource=00 → wraps to 0; resetn asserted during an outstanding fetch → req=0 immediately, following ack ignored, first post-reset fetch from RESET_PC.
